// File: rtl/ahb_pkg.sv
// Shared AHB definitions: transfer-type and response encodings plus the
// manager-index width helper used by the arbiter.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [1:0] HRESP_RETRY   = 2'b10;
    localparam logic [1:0] HRESP_SPLIT   = 2'b11;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ahb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after the current owner,
// wrapping modulo N, with the owner itself excluded.
module rr_pick
    import ahb_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [N-1:0]     owner_i,
    output logic [N-1:0]     winner_o,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             any_other_o
);

    logic [IDX_W-1:0] owner_idx_s;

    // One-hot owner to binary index.
    always_comb begin
        owner_idx_s = '0;
        for (int i = 0; i < N; i++) begin
            owner_idx_s = owner_idx_s | (owner_i[i] ? IDX_W'(i) : '0);
        end
    end

    // Scan owner+1 .. owner+N-1; the first requester found wins.
    always_comb begin
        int   sum_s;
        int   cand_s;
        logic take_s;
        sum_s       = 0;
        cand_s      = 0;
        take_s      = 1'b0;
        winner_o    = '0;
        win_idx_o   = '0;
        any_other_o = 1'b0;
        for (int k = 1; k < N; k++) begin
            sum_s            = int'(owner_idx_s) + k;
            cand_s           = (sum_s >= N) ? (sum_s - N) : sum_s;
            take_s           = req_i[cand_s] & ~any_other_o;
            winner_o[cand_s] = winner_o[cand_s] | take_s;
            win_idx_o        = take_s ? IDX_W'(cand_s) : win_idx_o;
            any_other_o      = any_other_o | take_s;
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB address-phase arbiter with burst/lock retention, a tenure
// limit, and one-cycle-delayed data-phase ownership tracking.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter int N_MANAGERS = 2,
    parameter int MAX_HOLD   = 4,
    parameter int IDX_WIDTH  = idx_width(N_MANAGERS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2*N_MANAGERS-1:0]   m_HTRANS,
    input  logic [N_MANAGERS-1:0]     m_HMASTLOCK,
    input  logic                      hready,
    output logic [N_MANAGERS-1:0]     grant,
    output logic [IDX_WIDTH-1:0]      grant_idx,
    output logic [N_MANAGERS-1:0]     dphase_grant,
    output logic                      dphase_valid
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W:0] MAX_HOLD_C = (HOLD_W + 1)'(MAX_HOLD);
    localparam logic [N_MANAGERS-1:0] GRANT_RST = {{(N_MANAGERS - 1){1'b0}}, 1'b1};

    logic [N_MANAGERS-1:0] grant_q,        grant_d;
    logic [IDX_WIDTH-1:0]  grant_idx_q,    grant_idx_d;
    logic [HOLD_W-1:0]     hold_cnt_q,     hold_cnt_d;
    logic [N_MANAGERS-1:0] dphase_grant_q, dphase_grant_d;
    logic                  dphase_valid_q, dphase_valid_d;

    logic [N_MANAGERS-1:0] req_s;
    logic [N_MANAGERS-1:0] win_s;
    logic [IDX_WIDTH-1:0]  win_idx_s;
    logic                  any_other_s;
    logic [1:0]            owner_trans_s;
    logic                  owner_lock_s;
    logic [HOLD_W:0]       cnt_n_s;

    // Request vector from each manager's HTRANS[1].
    always_comb begin
        req_s = '0;
        for (int i = 0; i < N_MANAGERS; i++) begin
            req_s[i] = m_HTRANS[2*i + 1];
        end
    end

    assign owner_trans_s = m_HTRANS[{grant_idx_q, 1'b0} +: 2];
    assign owner_lock_s  = m_HMASTLOCK[grant_idx_q];
    assign cnt_n_s       = {1'b0, hold_cnt_q} + (HOLD_W + 1)'(1);

    rr_pick #(
        .N     (N_MANAGERS),
        .IDX_W (IDX_WIDTH)
    ) u_rr_pick (
        .req_i       (req_s),
        .owner_i     (grant_q),
        .winner_o    (win_s),
        .win_idx_o   (win_idx_s),
        .any_other_o (any_other_s)
    );

    // Next state for an accepted (hready=1) edge; the register stage gates on hready.
    always_comb begin
        grant_d        = grant_q;
        grant_idx_d    = grant_idx_q;
        hold_cnt_d     = hold_cnt_q;
        dphase_grant_d = grant_q;
        dphase_valid_d = owner_trans_s[1];
        if (owner_lock_s) begin
            grant_d     = grant_q;
            grant_idx_d = grant_idx_q;
            hold_cnt_d  = hold_cnt_q;
        end else begin
            case (owner_trans_s)
                HTRANS_SEQ, HTRANS_BUSY: begin
                    grant_d     = grant_q;
                    grant_idx_d = grant_idx_q;
                    hold_cnt_d  = hold_cnt_q;
                end
                HTRANS_NONSEQ: begin
                    if ((cnt_n_s >= MAX_HOLD_C) && any_other_s) begin
                        grant_d     = win_s;
                        grant_idx_d = win_idx_s;
                        hold_cnt_d  = '0;
                    end else begin
                        grant_d     = grant_q;
                        grant_idx_d = grant_idx_q;
                        hold_cnt_d  = (cnt_n_s >= MAX_HOLD_C) ? MAX_HOLD_C[HOLD_W-1:0]
                                                              : cnt_n_s[HOLD_W-1:0];
                    end
                end
                HTRANS_IDLE: begin
                    hold_cnt_d = '0;
                    if (any_other_s) begin
                        grant_d     = win_s;
                        grant_idx_d = win_idx_s;
                    end else begin
                        grant_d     = grant_q;
                        grant_idx_d = grant_idx_q;
                    end
                end
                default: begin
                    grant_d     = grant_q;
                    grant_idx_d = grant_idx_q;
                    hold_cnt_d  = hold_cnt_q;
                end
            endcase
        end
    end

    // State registers; reset wins over a stalled bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q        <= GRANT_RST;
            grant_idx_q    <= '0;
            hold_cnt_q     <= '0;
            dphase_grant_q <= '0;
            dphase_valid_q <= 1'b0;
        end else if (hready) begin
            grant_q        <= grant_d;
            grant_idx_q    <= grant_idx_d;
            hold_cnt_q     <= hold_cnt_d;
            dphase_grant_q <= dphase_grant_d;
            dphase_valid_q <= dphase_valid_d;
        end
    end

    assign grant        = grant_q;
    assign grant_idx    = grant_idx_q;
    assign dphase_grant = dphase_grant_q;
    assign dphase_valid = dphase_valid_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Table-driven bench for ahb_arbiter with a 2-manager and a 3-manager instance.
module tb_ahb_arbiter;

    localparam logic [1:0] TI = 2'd0;
    localparam logic [1:0] TB = 2'd1;
    localparam logic [1:0] TN = 2'd2;
    localparam logic [1:0] TS = 2'd3;

    typedef struct {
        logic       sel;
        logic       rst;
        logic       hr;
        logic [5:0] tr;
        logic [2:0] lk;
        logic [2:0] g;
        logic [1:0] gi;
        logic [2:0] dg;
        logic       dv;
        logic [2:0] h;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic       clk = 1'b0;
    logic       rst2 = 1'b1;
    logic       rst3 = 1'b1;
    logic       hready = 1'b1;
    logic [3:0] htrans2 = 4'd0;
    logic [1:0] lock2 = 2'd0;
    logic [5:0] htrans3 = 6'd0;
    logic [2:0] lock3 = 3'd0;
    logic [1:0] grant2;
    logic [0:0] gidx2;
    logic [1:0] dg2;
    logic       dv2;
    logic [2:0] grant3;
    logic [1:0] gidx3;
    logic [2:0] dg3;
    logic       dv3;

    always #5 clk = ~clk;

    ahb_arbiter #(.N_MANAGERS(2), .MAX_HOLD(4), .IDX_WIDTH(1)) dut2 (
        .clk(clk), .rst(rst2), .m_HTRANS(htrans2), .m_HMASTLOCK(lock2), .hready(hready),
        .grant(grant2), .grant_idx(gidx2), .dphase_grant(dg2), .dphase_valid(dv2)
    );

    ahb_arbiter #(.N_MANAGERS(3), .MAX_HOLD(4), .IDX_WIDTH(2)) dut3 (
        .clk(clk), .rst(rst3), .m_HTRANS(htrans3), .m_HMASTLOCK(lock3), .hready(hready),
        .grant(grant3), .grant_idx(gidx3), .dphase_grant(dg3), .dphase_valid(dv3)
    );

    function automatic logic [5:0] tr(input logic [1:0] t2, input logic [1:0] t1, input logic [1:0] t0);
        return {t2, t1, t0};
    endfunction

    task automatic add(input logic a_sel, input logic a_rst, input logic a_hr, input logic [5:0] a_tr,
                       input logic [2:0] a_lk, input logic [2:0] a_g, input logic [1:0] a_gi,
                       input logic [2:0] a_dg, input logic a_dv, input logic [2:0] a_h);
        vec_t v;
        v.sel = a_sel; v.rst = a_rst; v.hr = a_hr; v.tr = a_tr; v.lk = a_lk;
        v.g = a_g; v.gi = a_gi; v.dg = a_dg; v.dv = a_dv; v.h = a_h;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        vec_t e;

        // 2 managers: reset, then parking with no requests
        add(1'b0, 1'b1, 1'b1, tr(TI, TI, TI), 3'd0, 3'd1, 2'd0, 3'd0, 1'b0, 3'd0);
        repeat (5) add(1'b0, 1'b0, 1'b1, tr(TI, TI, TI), 3'd0, 3'd1, 2'd0, 3'd1, 1'b0, 3'd0);

        // M0 burst (with one BUSY beat) while M1 keeps requesting
        add(1'b0, 1'b0, 1'b1, tr(TI, TN, TN), 3'd0, 3'd1, 2'd0, 3'd1, 1'b1, 3'd1);
        add(1'b0, 1'b0, 1'b1, tr(TI, TN, TS), 3'd0, 3'd1, 2'd0, 3'd1, 1'b1, 3'd1);
        add(1'b0, 1'b0, 1'b1, tr(TI, TN, TB), 3'd0, 3'd1, 2'd0, 3'd1, 1'b0, 3'd1);
        repeat (2) add(1'b0, 1'b0, 1'b1, tr(TI, TN, TS), 3'd0, 3'd1, 2'd0, 3'd1, 1'b1, 3'd1);
        add(1'b0, 1'b0, 1'b1, tr(TI, TN, TI), 3'd0, 3'd2, 2'd1, 3'd1, 1'b0, 3'd0);
        add(1'b0, 1'b0, 1'b1, tr(TI, TN, TI), 3'd0, 3'd2, 2'd1, 3'd2, 1'b1, 3'd1);

        // Back-to-back NONSEQ from both: tenure of MAX_HOLD=4 each
        add(1'b0, 1'b1, 1'b1, tr(TI, TN, TN), 3'd0, 3'd1, 2'd0, 3'd0, 1'b0, 3'd0);
        for (int k = 0; k < 12; k++) begin
            logic [2:0] own;
            logic [2:0] oth;
            own = ((k / 4) % 2 == 0) ? 3'd1 : 3'd2;
            oth = ((k / 4) % 2 == 0) ? 3'd2 : 3'd1;
            if (k % 4 == 3)
                add(1'b0, 1'b0, 1'b1, tr(TI, TN, TN), 3'd0, oth, 2'(oth >> 1), own, 1'b1, 3'd0);
            else
                add(1'b0, 1'b0, 1'b1, tr(TI, TN, TN), 3'd0, own, 2'(own >> 1), own, 1'b1, 3'(k % 4 + 1));
        end

        // Wait states freeze everything, including a pending switch
        add(1'b0, 1'b1, 1'b1, tr(TI, TN, TN), 3'd0, 3'd1, 2'd0, 3'd0, 1'b0, 3'd0);
        for (int k = 0; k < 3; k++)
            add(1'b0, 1'b0, 1'b1, tr(TI, TN, TN), 3'd0, 3'd1, 2'd0, 3'd1, 1'b1, 3'(k + 1));
        repeat (3) add(1'b0, 1'b0, 1'b0, tr(TI, TN, TN), 3'd0, 3'd1, 2'd0, 3'd1, 1'b1, 3'd3);
        add(1'b0, 1'b0, 1'b1, tr(TI, TN, TN), 3'd0, 3'd2, 2'd1, 3'd1, 1'b1, 3'd0);

        // Reset during a wait state mid-burst
        add(1'b0, 1'b1, 1'b0, tr(TI, TN, TS), 3'd0, 3'd1, 2'd0, 3'd0, 1'b0, 3'd0);

        // Lock: never pre-empted, hold count frozen; release then idle hands over
        for (int k = 0; k < 3; k++)
            add(1'b0, 1'b0, 1'b1, tr(TI, TN, TN), 3'd0, 3'd1, 2'd0, 3'd1, 1'b1, 3'(k + 1));
        repeat (10) add(1'b0, 1'b0, 1'b1, tr(TI, TN, TN), 3'd1, 3'd1, 2'd0, 3'd1, 1'b1, 3'd3);
        add(1'b0, 1'b0, 1'b1, tr(TI, TN, TI), 3'd0, 3'd2, 2'd1, 3'd1, 1'b0, 3'd0);

        // 3 managers: rotation order, reset mid-burst, wrap-around
        add(1'b1, 1'b1, 1'b1, tr(TI, TI, TI), 3'd0, 3'd1, 2'd0, 3'd0, 1'b0, 3'd0);
        add(1'b1, 1'b0, 1'b1, tr(TI, TN, TI), 3'd0, 3'd2, 2'd1, 3'd1, 1'b0, 3'd0);
        add(1'b1, 1'b0, 1'b1, tr(TN, TI, TN), 3'd0, 3'd4, 2'd2, 3'd2, 1'b0, 3'd0);
        add(1'b1, 1'b0, 1'b1, tr(TN, TI, TN), 3'd0, 3'd4, 2'd2, 3'd4, 1'b1, 3'd1);
        add(1'b1, 1'b0, 1'b1, tr(TS, TI, TN), 3'd0, 3'd4, 2'd2, 3'd4, 1'b1, 3'd1);
        add(1'b1, 1'b1, 1'b0, tr(TS, TI, TN), 3'd0, 3'd1, 2'd0, 3'd0, 1'b0, 3'd0);
        add(1'b1, 1'b0, 1'b1, tr(TN, TI, TI), 3'd0, 3'd4, 2'd2, 3'd1, 1'b0, 3'd0);
        add(1'b1, 1'b0, 1'b1, tr(TI, TN, TN), 3'd0, 3'd1, 2'd0, 3'd4, 1'b0, 3'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            hready = v.hr;
            if (v.sel == 1'b0) begin
                rst2    = v.rst;
                htrans2 = v.tr[3:0];
                lock2   = v.lk[1:0];
            end else begin
                rst3    = v.rst;
                htrans3 = v.tr;
                lock3   = v.lk;
            end
            exp_q.push_back(v);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            if (e.sel == 1'b0) begin
                check("grant",        i, 32'(grant2),           32'(e.g));
                check("grant_idx",    i, 32'(gidx2),            32'(e.gi));
                check("dphase_grant", i, 32'(dg2),              32'(e.dg));
                check("dphase_valid", i, 32'(dv2),              32'(e.dv));
                check("hold_cnt",     i, 32'(dut2.hold_cnt_q),  32'(e.h));
            end else begin
                check("grant3",        i, 32'(grant3),          32'(e.g));
                check("grant_idx3",    i, 32'(gidx3),           32'(e.gi));
                check("dphase_grant3", i, 32'(dg3),             32'(e.dg));
                check("dphase_valid3", i, 32'(dv3),             32'(e.dv));
                check("hold_cnt3",     i, 32'(dut3.hold_cnt_q), 32'(e.h));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
